char_queue_loader: RTL
======================

// Module: char_queue_loader
// PURPOSE
//  Upstream feeder for the cipher stage. Captures 5-bit letter codes (a=0 .. z=25) from the switches on KEY-style
//  active-low button presses and holds them in a FIFO message queue. On a go press it streams the queue out one letter
//  per accepted transfer over a valid/ready handshake. The downstream cipher consumes this stream in place of a single
//  latched char.
// PARAMETERS
//  DEPTH     8   queue entries; power of two, >= 2
//  CHAR_W    5   letter code width
//  MAX_CHAR  25  highest legal code ('z'); codes above it are rejected
// PORTS
//  clk          in   1          system clock, single domain; all logic on posedge
//  reset        in   1          synchronous, active-high; overrides every other input
//  load_n       in   1          async active-low button: push char_in
//  go_n         in   1          async active-low button: start streaming
//  clear        in   1          synchronous, active-high: flush queue, abort stream
//  char_in      in   CHAR_W     letter code sampled on the load press
//  out_char     out  CHAR_W     head-of-queue letter; 0 when out_valid=0
//  out_valid    out  1          out_char valid (STREAM state)
//  out_ready    in   1          consumer accepts out_char this cycle
//  out_last     out  1          out_valid and this is the final queued letter
//  count        out  log2(DEPTH)+1  entries currently queued
//  empty, full  out  1          count==0 / count==DEPTH
//  busy         out  1          state==STREAM
//  err_invalid  out  1          1-cycle pulse: load rejected, char_in > MAX_CHAR
//  err_overflow out  1          1-cycle pulse: load rejected, queue full
// BEHAVIOUR
//  Reset: state=IDLE, rd_ptr=wr_ptr=0, count=0, empty=1, full=0, busy=0, out_valid=0, out_char=0, out_last=0,
//   err_*=0, synchronizer flops=1. Queue storage is not cleared.
//  Button conditioning: per button, flops s1<=btn, s2<=s1, s3<=s2; press = s3 & ~s2; one press per high->low
//   transition regardless of hold length. If the button is first sampled low at edge N, the action commits at edge N+2.
//  Load press, IDLE: char_in > MAX_CHAR -> drop, err_invalid=1 for one cycle. Else if full -> drop, err_overflow=1 for
//   one cycle. Else mem[wr_ptr]<=char_in, wr_ptr+1 (wraps mod DEPTH), count+1. char_in is sampled at the commit edge.
//  Load press, STREAM: ignored silently; no error pulse.
//  Go press, IDLE: count!=0 before the edge -> STREAM; count==0 -> ignored. Go press in STREAM is ignored.
//  FSM IDLE<->STREAM:
//   - STREAM: out_valid=1 and out_char=mem[rd_ptr], both combinational from state/rd_ptr.
//   - On out_valid&out_ready: rd_ptr+1 (wraps), count-1.
//   - If count==1 at that edge -> IDLE.
//   - out_char holds stable while out_ready=0; there is no timeout.
//  Load and go presses in the same cycle, IDLE:
//   - count!=0 -> push commits AND the FSM enters STREAM; the new letter is streamed last.
//   - count==0 -> push commits, go ignored.
//  clear: count=0, pointers=0, state=IDLE, out_valid=0 next cycle. A load press in the same cycle as clear is discarded.
//   A transfer in the same cycle as clear is voided.
//  Priority: reset > clear > transfer/pop > load push; push and pop in the same cycle cannot occur (push only in IDLE).
//  Reset or clear mid-stream: remaining letters are lost and no further out_valid is asserted.
//  Throughput: one letter per cycle when out_ready is held high.
// TESTING
//  1) Reset, then load 7,0,25 (separate presses), go, out_ready=1 -> out_char 7,0,25 on consecutive cycles; out_last
//     only with 25; count 3->0; busy drops after the third transfer.
//  2) Hold load_n low 50 cycles with char_in=4 -> exactly one push, count=1. char_in=26 press -> err_invalid pulse,
//     count unchanged.
//  3) Fill DEPTH=8 entries, ninth press -> err_overflow pulse, full=1. Stream all 8 -> order preserved across pointer
//     wrap after a refill of 3.
//  4) Stream 3 letters with out_ready toggling 1,0,0,1,1 -> out_char stable while stalled; exactly 3 transfers.
//  5) clear asserted after the first transfer of a 4-letter stream -> out_valid=0 next cycle, count=0, busy=0.
//     Go on empty queue -> no STREAM.
//  6) reset pulse during STREAM -> all outputs at reset values next cycle. Simultaneous load+go with count=2 -> 3
//     letters streamed.

Source files
------------

// File: rtl/char_queue_loader.sv
// rtl/char_queue_loader.sv - button-driven letter FIFO that streams its contents over a valid/ready handshake
module char_queue_loader #(
  parameter int DEPTH    = 8,
  parameter int CHAR_W   = 5,
  parameter int MAX_CHAR = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_n,
  input  logic                     go_n,
  input  logic                     clear,
  input  logic [CHAR_W-1:0]        char_in,
  output logic [CHAR_W-1:0]        out_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     busy,
  output logic                     err_invalid,
  output logic                     err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CHAR_W-1:0] MAX_CODE  = CHAR_W'(MAX_CHAR);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CHAR_W-1:0] mem [DEPTH];

  logic load_s1, load_s2, load_s3;
  logic go_s1, go_s2, go_s3;
  logic load_press, go_press;
  logic push_ok;

  // Three-flop chains per button: two for metastability, the third to find the falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      load_s1 <= 1'b1;
      load_s2 <= 1'b1;
      load_s3 <= 1'b1;
      go_s1   <= 1'b1;
      go_s2   <= 1'b1;
      go_s3   <= 1'b1;
    end else begin
      load_s1 <= load_n;
      load_s2 <= load_s1;
      load_s3 <= load_s2;
      go_s1   <= go_n;
      go_s2   <= go_s1;
      go_s3   <= go_s2;
    end
  end

  assign load_press = load_s3 & ~load_s2;
  assign go_press   = go_s3 & ~go_s2;

  assign empty     = (count == '0);
  assign full      = (count == CNT_DEPTH);
  assign busy      = (state == STREAM);
  assign out_valid = (state == STREAM);
  assign out_char  = out_valid ? mem[rd_ptr] : '0;
  assign out_last  = out_valid && (count == CNT_ONE);

  // A push lands only in IDLE with a legal code, free space and no clear competing for the cycle
  assign push_ok = load_press && (state == IDLE) && !clear && (char_in <= MAX_CODE) && !full;

  // Queue storage; deliberately not reset, stale entries are unreachable once count is zero
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= char_in;
    end
  end

  // Control: reset beats clear, clear beats transfers, transfers and pushes are mutually exclusive by state
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_invalid  <= 1'b0;
      err_overflow <= 1'b0;
      if (clear) begin
        state  <= IDLE;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else if (state == STREAM) begin
        if (out_ready) begin
          rd_ptr <= rd_ptr + PTR_ONE;
          count  <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            state <= IDLE;
          end
        end
      end else begin
        if (load_press) begin
          if (char_in > MAX_CODE) begin
            err_invalid <= 1'b1;
          end else if (full) begin
            err_overflow <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
          end
        end
        // Go looks at the pre-edge count, so a same-cycle push on an empty queue does not start a stream
        if (go_press && (count != '0)) begin
          state <= STREAM;
        end
      end
    end
  end

endmodule
